fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch stage that replaces the single instruction register between memory and CPU. It issues sequential fetch requests to instruction memory over a request/grant/response handshake and keeps several requests in flight. Returned words go into a DEPTH-entry prefetch FIFO. Each word is delivered to the CPU with its PC over a valid/ready handshake, and a redirect from the CPU (branch or jump) flushes the buffer and all in-flight responses.

Parameters:
XLEN, 32, width of PC, address and instruction data
DEPTH, 4, prefetch FIFO entries; also the cap on FIFO occupancy plus in-flight requests; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clk and a synchronous active-high reset, sampled on posedge clk
mem_req  output  1  fetch request valid
mem_addr  output  XLEN  fetch byte address, low 2 bits always 0
mem_gnt  input  1  memory accepts the request this cycle (counts only when mem_req=1)
mem_rvalid  input  1  response word valid; responses return in request order, at least 1 cycle after grant
mem_rdata  input  XLEN  response word
instr_valid  output  1  FIFO head holds an instruction
instr_ready  input  1  CPU consumes head this cycle
instr_data  output  XLEN  head instruction word
instr_pc  output  XLEN  PC of head instruction
redirect  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored and treated as 0

Behaviour:
- State registers:
  - fetch_pc: next address to request.
  - rsp_pc: PC tagged onto the next kept response.
  - inflight: granted requests not yet answered; width $clog2(DEPTH+1).
  - drop_cnt: in-flight responses to discard.
  - FIFO of {pc, data} pairs with head/tail pointers and a count.
- Reset, while reset is high at a clock edge:
  - fetch_pc = rsp_pc = RESET_PC.
  - inflight = drop_cnt = count = 0, pointers = 0.
  - Outputs during and after reset: mem_req=0, instr_valid=0, instr_data=0, instr_pc=0 (head read gated to 0 while empty).
  - A reset asserted mid-operation abandons everything. Responses that arrive after reset for pre-reset requests are not tracked; the memory side is reset together with this unit.
- Issue:
  - mem_req = !reset && !redirect && (count + (inflight - drop_cnt) < DEPTH) && (inflight < DEPTH).
  - mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc += 4 (wraps modulo 2^XLEN) and inflight += 1.
  - mem_req stays asserted until granted; mem_addr is stable while it waits.
- Response:
  - On mem_rvalid, inflight -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise push {rsp_pc, mem_rdata} into the FIFO and rsp_pc += 4.
  - The credit rule guarantees a push never meets a full FIFO. A response with inflight=0 is a protocol error; the bench asserts it never happens.
- Deliver:
  - instr_valid = (count != 0); instr_data/instr_pc = head entry.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Latency: grant at cycle N, rvalid at N+k, instr_valid high at N+k+1 (FIFO is registered; no bypass).
  - The head is held stable while instr_valid=1 and instr_ready=0.
- Redirect (has priority over pop, push and issue in the same cycle):
  - FIFO cleared: count=0, pointers reset.
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = inflight - (mem_rvalid ? 1 : 0); inflight is updated the same way.
  - No request is issued in the redirect cycle. Issue resumes the next cycle at the new PC.
  - Back-to-back redirects: each re-latches drop_cnt from the current inflight; the last redirect PC wins.
- Fetching continues indefinitely; there is no halt. Backpressure comes only from FIFO credits and mem_gnt.

Test Plan:
- Reset, then memory with grant always 1, 1-cycle latency, word=addr^32'hA5A5_0000, instr_ready=1 → first instr_valid 2 cycles after the first grant, pc=0x0 then 0x4, 0x8, …; one instruction per cycle sustained; data matches.
- instr_ready=0 held → FIFO fills to 4, mem_req drops to 0 with no 5th grant. Release ready → pcs 0x0,0x4,0x8,0xC delivered in order, then fetch resumes at 0x10.
- Memory latency 3, two requests in flight, redirect to 0x103 → issue resumes at 0x100. Both stale responses are discarded; the first delivered instruction has pc=0x100.
- Redirect in the same cycle as mem_rvalid and instr_valid&&instr_ready → the popped word is not double-counted, the arriving word is dropped, drop_cnt=inflight-1, and the next instr_pc equals the redirect target.
- mem_gnt held 0 for 5 cycles → mem_req stays 1 with mem_addr stable. fetch_pc near 0xFFFF_FFFC wraps to 0x0 after grant.
- Assert reset mid-stream with a full FIFO → next cycle instr_valid=0, mem_req=0. After deassert, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: keeps several sequential fetches in flight and buffers
// the returned words with their PCs in a small FIFO ahead of the CPU.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CW   = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];

  logic [CW:0]     used;
  logic            issue;
  logic            keep;
  logic            pop;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   inflight_after_rsp;

  always_comb begin
    // Credits cover both buffered words and responses that will actually be kept.
    used        = {1'b0, count} + {1'b0, inflight - drop_cnt};
    mem_req     = !reset && !redirect && (used < DEPTH_WIDE) && (inflight < DEPTH_CW);
    mem_addr    = fetch_pc;
    issue       = mem_req && mem_gnt;
    keep        = mem_rvalid && (drop_cnt == '0);
    instr_valid = (count != '0);
    pop         = instr_valid && instr_ready;
    instr_data  = instr_valid ? fifo_data[head] : '0;
    instr_pc    = instr_valid ? fifo_pc[head]   : '0;
    target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    inflight_after_rsp = inflight - CW'(mem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect) begin
      fetch_pc <= target_pc;
      rsp_pc   <= target_pc;
      inflight <= inflight_after_rsp;
      drop_cnt <= inflight_after_rsp;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      inflight <= inflight + CW'(issue) - CW'(mem_rvalid);
      if (mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (keep) begin
        fifo_pc[tail]   <= rsp_pc;
        fifo_data[tail] <= mem_rdata;
        tail            <= tail + PW'(1);
        rsp_pc          <= rsp_pc + XLEN'(4);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(keep) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;

  rsp_t        pend[$];
  int unsigned edges = 0;
  int unsigned lat = 1;
  int unsigned gcount = 0;
  int          total = 0;
  int          bad = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_data;

  // One clock: sample outputs mid-cycle, then advance memory model past the edge.
  task automatic tick();
    logic rv_s, gr_s, rs_s;
    rsp_t r;
    @(negedge clk);
    s_req   = mem_req;
    s_addr  = mem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_data  = instr_data;
    rv_s    = mem_rvalid;
    gr_s    = mem_req && mem_gnt;
    rs_s    = reset;
    @(posedge clk);
    #1;
    edges++;
    if (rs_s) begin
      pend.delete();
    end else begin
      if (rv_s && pend.size() > 0) void'(pend.pop_front());
      if (gr_s) begin
        r.addr = s_addr;
        r.due  = edges + lat;
        pend.push_back(r);
        gcount++;
      end
    end
    if (pend.size() > 0 && pend[0].due <= edges + 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].addr ^ 32'hA5A5_0000;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    mem_gnt     = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    chk("rst_req",   32'(s_req),   32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data",  s_data,       32'd0);
    chk("rst_pc",    s_pc,         32'd0);
    reset  = 1'b0;
    gcount = 0;
  endtask

  initial begin
    // Streaming with 1-cycle memory and a ready CPU.
    do_reset();
    lat = 1; mem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    chk("s_req0",   32'(s_req),   32'd1);
    chk("s_addr0",  s_addr,       32'h0);
    chk("s_val0",   32'(s_valid), 32'd0);
    tick();
    chk("s_val1",   32'(s_valid), 32'd0);
    chk("s_addr1",  s_addr,       32'h4);
    tick();
    chk("s_first_valid", 32'(s_valid), 32'd1);
    chk("s_first_pc",    s_pc,         32'h0);
    chk("s_first_data",  s_data,       32'hA5A5_0000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("s_valid", 32'(s_valid), 32'd1);
      chk("s_pc",    s_pc,         32'(4 * i));
      chk("s_data",  s_data,       32'(4 * i) ^ 32'hA5A5_0000);
    end

    // Backpressure fills the FIFO and stops issue at four outstanding words.
    do_reset();
    lat = 1; mem_gnt = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("full_req",    32'(s_req),   32'd0);
    chk("full_grants", gcount,       32'd4);
    chk("full_valid",  32'(s_valid), 32'd1);
    chk("full_pc",     s_pc,         32'h0);
    instr_ready = 1'b1;
    tick();
    chk("rel_pc0",  s_pc,       32'h0);
    chk("rel_req0", 32'(s_req), 32'd0);
    tick();
    chk("rel_pc4",  s_pc,       32'h4);
    chk("rel_req1", 32'(s_req), 32'd1);
    chk("rel_addr", s_addr,     32'h10);
    tick();
    chk("rel_pc8",  s_pc,       32'h8);
    tick();
    chk("rel_pcC",  s_pc,       32'hC);
    tick();
    chk("rel_pc10", s_pc,       32'h10);

    // Redirect with two stale requests in flight at latency 3.
    do_reset();
    lat = 3; mem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    chk("rd_req_blocked", 32'(s_req), 32'd0);
    redirect = 1'b0;
    tick();
    chk("rd_req",  32'(s_req), 32'd1);
    chk("rd_addr", s_addr,     32'h100);
    tick();
    tick();
    tick();
    chk("rd_stale_dropped", 32'(s_valid), 32'd0);
    tick();
    chk("rd_valid", 32'(s_valid), 32'd1);
    chk("rd_pc",    s_pc,         32'h100);
    chk("rd_data",  s_data,       32'hA5A5_0100);
    tick();
    chk("rd_pc2",   s_pc,         32'h104);

    // Redirect coinciding with a response and a pop, latency 2.
    do_reset();
    lat = 2; mem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    chk("co_valid", 32'(s_valid), 32'd1);
    chk("co_pc",    s_pc,         32'h0);
    chk("co_req",   32'(s_req),   32'd0);
    redirect = 1'b0;
    tick();
    chk("co_valid_after", 32'(s_valid), 32'd0);
    chk("co_addr",        s_addr,       32'h200);
    tick();
    tick();
    chk("co_dropped", 32'(s_valid), 32'd0);
    tick();
    chk("co_new_valid", 32'(s_valid), 32'd1);
    chk("co_new_pc",    s_pc,         32'h200);
    chk("co_new_data",  s_data,       32'hA5A5_0200);

    // Grant stall keeps the request stable; then address wrap.
    do_reset();
    lat = 1; mem_gnt = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req",  32'(s_req), 32'd1);
      chk("stall_addr", s_addr,     32'h0);
    end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    chk("wr_req_blocked", 32'(s_req), 32'd0);
    redirect = 1'b0; mem_gnt = 1'b1;
    tick();
    chk("wr_req",   32'(s_req), 32'd1);
    chk("wr_addr0", s_addr,     32'hFFFF_FFFC);
    tick();
    chk("wr_addr1", s_addr,     32'h0);
    tick();
    chk("wr_pc0",   s_pc,       32'hFFFF_FFFC);
    chk("wr_data0", s_data,     32'h5A5A_FFFC);
    tick();
    chk("wr_pc1",   s_pc,       32'h0);
    chk("wr_data1", s_data,     32'hA5A5_0000);

    // Reset with a full FIFO abandons everything.
    do_reset();
    lat = 1; mem_gnt = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mr_full_valid", 32'(s_valid), 32'd1);
    do_reset();
    mem_gnt = 1'b1; instr_ready = 1'b1;
    tick();
    chk("mr_valid", 32'(s_valid), 32'd0);
    chk("mr_req",   32'(s_req),   32'd1);
    chk("mr_addr",  s_addr,       32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
